// File: rtl/recovery_action_ctrl.sv
// Fault-recovery sequencer: redirects fetch to the checkpoint PC, flushes with NOP
// bubbles, pulses a retry strobe, and locks into FAIL once the retry budget is spent.
module recovery_action_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NOP_CYCLES  = 2,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               recovery_en,
  input  logic [XLEN-1:0]                    pc_current,
  input  logic [XLEN-1:0]                    pc_saved,
  output logic [XLEN-1:0]                    pc_next,
  output logic                               insert_nop,
  output logic                               retry_en,
  output logic                               recovery_busy,
  output logic                               recovery_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int unsigned CW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned FW = $clog2(NOP_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_RETRIES);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(NOP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RETRY = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] target_pc;
  logic [FW-1:0]   flush_cnt;
  logic            nop_q;
  logic            retry_q;
  logic            busy_q;
  logic            fail_q;
  logic            take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      target_pc   <= '0;
      flush_cnt   <= '0;
      retry_count <= '0;
      nop_q       <= 1'b0;
      retry_q     <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (recovery_en) begin
            target_pc <= pc_saved;
            flush_cnt <= FLUSH_LOAD;
            busy_q    <= 1'b1;
            nop_q     <= 1'b1;
            // A new target or a fresh count restarts the budget at one retry.
            if (pc_saved != target_pc || retry_count == '0) begin
              retry_count <= CW'(1);
              state       <= FLUSH;
            end else if (retry_count < MAX_CNT) begin
              retry_count <= retry_count + CW'(1);
              state       <= FLUSH;
            end else begin
              fail_q <= 1'b1;
              state  <= FAIL;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(1)) begin
            state   <= RETRY;
            nop_q   <= 1'b0;
            retry_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        RETRY: begin
          state   <= IDLE;
          retry_q <= 1'b0;
          busy_q  <= 1'b0;
          nop_q   <= 1'b0;
        end
        FAIL: begin
          state <= FAIL;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Redirect in IDLE is combinational so the trigger cycle itself fetches the checkpoint.
  always_comb begin
    take          = (state == IDLE) && recovery_en && rst_n;
    pc_next       = pc_current;
    insert_nop    = 1'b0;
    if (state == IDLE) begin
      if (take) begin
        pc_next    = pc_saved;
        insert_nop = 1'b1;
      end
    end else begin
      pc_next    = target_pc;
      insert_nop = nop_q;
    end
    retry_en      = retry_q;
    recovery_busy = busy_q;
    recovery_fail = fail_q;
  end

endmodule

// File: tb/tb_recovery_action_ctrl.sv
// Bench for recovery_action_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based schedule model of the recovery sequence.
module tb_recovery_action_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NOP  = 2;
  localparam int unsigned MAXR = 3;
  localparam int unsigned CW   = $clog2(MAXR + 1);
  localparam int unsigned VW   = XLEN + 4 + CW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            recovery_en;
  logic [XLEN-1:0] pc_current;
  logic [XLEN-1:0] pc_saved;
  logic [XLEN-1:0] pc_next;
  logic            insert_nop;
  logic            retry_en;
  logic            recovery_busy;
  logic            recovery_fail;
  logic [CW-1:0]   retry_count;

  recovery_action_ctrl #(
    .XLEN       (XLEN),
    .NOP_CYCLES (NOP),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .recovery_en  (recovery_en),
    .pc_current   (pc_current),
    .pc_saved     (pc_saved),
    .pc_next      (pc_next),
    .insert_nop   (insert_nop),
    .retry_en     (retry_en),
    .recovery_busy(recovery_busy),
    .recovery_fail(recovery_fail),
    .retry_count  (retry_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a schedule of upcoming busy cycles (0 = flush, 1 = retry).
  bit              sched[$];
  bit              m_fail;
  logic [XLEN-1:0] m_target;
  int              m_count;
  logic [VW-1:0]   exp_vec;
  logic [VW-1:0]   obs_vec;

  task automatic model_reset();
    sched.delete();
    m_fail   = 1'b0;
    m_target = '0;
    m_count  = 0;
  endtask

  task automatic model_expect();
    logic [XLEN-1:0] pc;
    bit nop, rty, busy;
    if (!rst_n) begin
      pc = pc_current; nop = 0; rty = 0; busy = 0;
    end else if (m_fail) begin
      pc = m_target; nop = 1; rty = 0; busy = 1;
    end else if (sched.size() > 0) begin
      pc = m_target; nop = !sched[0]; rty = sched[0]; busy = 1;
    end else begin
      pc = recovery_en ? pc_saved : pc_current;
      nop = recovery_en; rty = 0; busy = 0;
    end
    exp_vec = {pc, nop, rty, busy, m_fail, CW'(m_count)};
  endtask

  task automatic model_update();
    bool_accept: begin
      if (m_fail) begin
      end else if (sched.size() > 0) begin
        void'(sched.pop_front());
      end else if (recovery_en) begin
        if (pc_saved != m_target || m_count == 0) m_count = 1;
        else if (m_count < MAXR) m_count = m_count + 1;
        else m_fail = 1'b1;
        if (!m_fail) begin
          repeat (NOP) sched.push_back(1'b0);
          sched.push_back(1'b1);
        end
        m_target = pc_saved;
      end
    end
  endtask

  task automatic drive(input bit r, input bit en, input logic [XLEN-1:0] cur,
                       input logic [XLEN-1:0] saved);
    @(negedge clk);
    rst_n = r; recovery_en = en; pc_current = cur; pc_saved = saved;
    if (!r) model_reset();
    model_expect();
    #1;
    obs_vec = {pc_next, insert_nop, retry_en, recovery_busy, recovery_fail, retry_count};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 32'h10, 32'h08);
    n_vec++;
    if (pc_next !== 32'h10 || insert_nop !== 1'b0 || retry_en !== 1'b0 ||
        recovery_busy !== 1'b0 || recovery_fail !== 1'b0 || retry_count !== '0) begin
      n_err++;
      $display("FAIL reset: got pc=%h nop=%b rty=%b busy=%b fail=%b cnt=%0d, exp pc=10 all zero",
               pc_next, insert_nop, retry_en, recovery_busy, recovery_fail, retry_count);
    end
    tick();
  endtask

  task automatic test_idle_passthrough();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h08);
      n_vec++;
      if (obs_vec !== exp_vec || pc_next !== 32'h10 || insert_nop !== 1'b0) begin
        n_err++;
        $display("FAIL idle_pass[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  // One-cycle request: trigger, two flush, one retry, then idle.
  task automatic test_single_recovery();
    logic [XLEN-1:0] lpc[5]  = '{32'h08, 32'h08, 32'h08, 32'h08, 32'h10};
    bit              lnop[5] = '{1, 1, 1, 0, 0};
    bit              lrty[5] = '{0, 0, 0, 1, 0};
    bit              lbsy[5] = '{0, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, 32'h10, 32'h08);
      n_vec++;
      if (pc_next !== lpc[i] || insert_nop !== lnop[i] || retry_en !== lrty[i] ||
          recovery_busy !== lbsy[i] || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL single_rec[%0d]: got pc=%h nop=%b rty=%b busy=%b (vec %h) exp pc=%h nop=%b rty=%b busy=%b (vec %h)",
                 i, pc_next, insert_nop, retry_en, recovery_busy, obs_vec,
                 lpc[i], lnop[i], lrty[i], lbsy[i], exp_vec);
      end
      tick();
    end
    drive(1'b1, 1'b0, 32'h10, 32'h08);
    n_vec++;
    if (retry_count !== CW'(1)) begin
      n_err++;
      $display("FAIL single_rec_count: got %0d exp 1", retry_count);
    end
    tick();
  endtask

  task automatic test_exhaustion();
    test_reset();
    for (int req = 1; req <= MAXR + 1; req++) begin
      for (int c = 0; c < NOP + 2; c++) begin
        drive(1'b1, c == 0, 32'h10, 32'h08);
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL exhaust[%0d.%0d]: got %h exp %h", req, c, obs_vec, exp_vec);
        end
        tick();
      end
      if (req <= MAXR) begin
        drive(1'b1, 1'b0, 32'h10, 32'h08);
        n_vec++;
        if (retry_count !== CW'(req)) begin
          n_err++;
          $display("FAIL exhaust_count[%0d]: got %0d exp %0d", req, retry_count, req);
        end
        tick();
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], 32'h10, 32'h44);
      n_vec++;
      if (recovery_fail !== 1'b1 || insert_nop !== 1'b1 || pc_next !== 32'h08 ||
          retry_en !== 1'b0 || retry_count !== CW'(MAXR)) begin
        n_err++;
        $display("FAIL fail_state[%0d]: got fail=%b nop=%b pc=%h rty=%b cnt=%0d exp 1 1 08 0 %0d",
                 i, recovery_fail, insert_nop, pc_next, retry_en, retry_count, MAXR);
      end
      tick();
    end
  endtask

  task automatic test_target_change();
    test_reset();
    for (int req = 0; req < 3; req++) begin
      for (int c = 0; c < NOP + 2; c++) begin
        drive(1'b1, c == 0, 32'h10, req < 2 ? 32'h08 : 32'h20);
        n_vec++;
        if (obs_vec !== exp_vec || (req == 2 && c > 0 && pc_next !== 32'h20)) begin
          n_err++;
          $display("FAIL target_chg[%0d.%0d]: got %h exp %h", req, c, obs_vec, exp_vec);
        end
        tick();
      end
    end
    drive(1'b1, 1'b0, 32'h10, 32'h20);
    n_vec++;
    if (retry_count !== CW'(1)) begin
      n_err++;
      $display("FAIL target_chg_count: got %0d exp 1", retry_count);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 1'b1, 32'h30, 32'h08);
    tick();
    drive(1'b1, 1'b0, 32'h30, 32'h08);
    tick();
    drive(1'b0, 1'b0, 32'h30, 32'h08);
    n_vec++;
    if (insert_nop !== 1'b0 || recovery_busy !== 1'b0 || pc_next !== 32'h30 ||
        retry_count !== '0 || retry_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_flush: got nop=%b busy=%b pc=%h cnt=%0d rty=%b exp 0 0 30 0 0",
               insert_nop, recovery_busy, pc_next, retry_count, retry_en);
    end
    tick();
    for (int i = 0; i < NOP + 3; i++) begin
      drive(1'b1, 1'b0, 32'h30, 32'h08);
      n_vec++;
      if (retry_en !== 1'b0 || obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL post_reset[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] targets[3] = '{32'h08, 32'h20, 32'h40};
    bit r, en;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      en = ($urandom_range(0, 2) == 0);
      drive(r, en, $urandom, targets[$urandom_range(0, 2)]);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 3 * (NOP + 2) + 4; i++) begin
      drive(1'b1, 1'b1, 32'h10, 32'h08);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; recovery_en = 1'b0; pc_current = '0; pc_saved = '0;
    model_reset();
    test_reset();
    test_idle_passthrough();
    test_single_recovery();
    test_exhaustion();
    test_target_change();
    test_reset_mid_flush();
    test_back_to_back();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/recovery_action_ctrl.md
Name: recovery_action_ctrl

Overview:
- Fault-recovery sequencer between the error detector and the fetch/PC-select stage of the fault-tolerant RISC-V core.
- On a recovery request it redirects fetch to the saved checkpoint PC, injects NOP bubbles to flush the pipeline, and then pulses a retry strobe.
- It counts consecutive retries to the same checkpoint and locks into a fail state when the retry budget is exhausted.

Parameters:
- XLEN, 32, PC width.
- NOP_CYCLES, 2, flush cycles after the trigger cycle (>=1).
- MAX_RETRIES, 3, accepted recoveries to the same checkpoint before fail (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- recovery_en  input  1  recovery request, level-sampled.
- pc_current  input  XLEN  normal next-fetch PC from fetch logic.
- pc_saved  input  XLEN  checkpoint PC to restart from.
- pc_next  output  XLEN  PC that fetch must use this cycle.
- insert_nop  output  1  replace fetched/decoded instruction with NOP.
- retry_en  output  1  one-cycle strobe: re-execution starts.
- recovery_busy  output  1  high in any state other than IDLE.
- recovery_fail  output  1  sticky retry-budget-exhausted flag.
- retry_count  output  CW  consecutive retries to current target, CW = $clog2(MAX_RETRIES+1).

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; target_pc, flush counter and retry_count = 0; recovery_fail=0.
  - Combinational outputs while in reset: pc_next=pc_current, insert_nop=0, retry_en=0, busy=0.
- State IDLE:
  - recovery_en=0: pc_next=pc_current, insert_nop=0, retry_en=0.
  - recovery_en=1: zero-latency redirect; same cycle, combinationally, pc_next=pc_saved and insert_nop=1.
  - At that clock edge: target_pc<=pc_saved; flush counter<=NOP_CYCLES.
- Retry bookkeeping, evaluated at the accepting edge:
  - If pc_saved != stored target_pc, or retry_count==0: retry_count<=1, next=FLUSH.
  - Else if retry_count<MAX_RETRIES: retry_count<=retry_count+1, next=FLUSH.
  - Else: next=FAIL; retry_count holds.
- State FLUSH:
  - Outputs: pc_next=target_pc, insert_nop=1, retry_en=0.
  - Counter decrements each cycle; when it reaches 1, next=RETRY.
  - Total NOP cycles = 1 (trigger) + NOP_CYCLES.
- State RETRY, exactly one cycle:
  - Outputs: pc_next=target_pc, insert_nop=0, retry_en=1; next=IDLE.
- State FAIL:
  - Outputs: pc_next=target_pc, insert_nop=1 (permanent stall), retry_en=0, recovery_fail=1.
  - Left only by reset.
- recovery_busy = (state != IDLE).
- recovery_en while in FLUSH/RETRY/FAIL is ignored; it is not queued. A request held high through RETRY is re-accepted in the next IDLE cycle.
- A new request in IDLE with the same pc_saved continues the count. A different pc_saved restarts the count at 1 and updates target_pc.
- retry_count and target_pc persist in IDLE; only reset or a new target changes them.
- All PC values pass through unmodified. No arithmetic on PCs; comparisons are full XLEN equality.
- Reset asserted mid-FLUSH/RETRY/FAIL returns immediately to IDLE with reset values; no retry_en is emitted.

Test Plan:
- Idle pass-through: reset, then recovery_en=0, pc_current=0x10, pc_saved=0x08 -> pc_next=0x10, insert_nop=0, retry_en=0, busy=0.
- Single recovery: recovery_en=1 for one cycle -> cycle0 pc_next=0x08 with insert_nop=1; then 2 FLUSH cycles with pc_next=0x08 and insert_nop=1; then 1 cycle retry_en=1 with insert_nop=0; then IDLE with pc_next=0x10 and retry_count=1.
- Request drop after one cycle: recovery_en 1 then 0 -> sequence completes unchanged; busy high for exactly 3 cycles.
- Retry exhaustion: four separate requests with pc_saved=0x08 -> retry_count 1,2,3. Fourth request -> FAIL: recovery_fail=1, insert_nop=1 held, pc_next=0x08, no retry_en.
- Target change: after 2 retries to 0x08, request with pc_saved=0x20 -> retry_count=1, pc_next=0x20 during FLUSH.
- Reset mid-FLUSH: drop rst_n during FLUSH -> immediately insert_nop=0, busy=0, pc_next=pc_current; no retry_en after release.
